// File: rtl/muxsel_adder_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muxsel_adder_pipe_if : operand/result handshake bundle for muxsel_adder_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
interface muxsel_adder_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] b1;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             all_ones;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output in_valid, sel, a0, a1, b0, b1, cin, out_ready,
    input  in_ready, out_valid, sum, cout, all_ones, done_cnt
  );

  modport slave (
    input  in_valid, sel, a0, a1, b0, b1, cin, out_ready,
    output in_ready, out_valid, sum, cout, all_ones, done_cnt
  );
endinterface

`default_nettype wire

// File: rtl/muxsel_adder_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muxsel_adder_pipe : per-bit mux-selected operand adder, 1- or 2-stage
//                     valid/ready pipe; define SAT_EN to saturate on overflow
// Rev 1.0
// ----------------------------------------------------------------------------
module muxsel_adder_pipe #(
  parameter int WIDTH = 4,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  muxsel_adder_pipe_if.slave bus
);
  localparam int c_half = WIDTH / 2;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_res_raw;
  logic [WIDTH-1:0] w_sum_fin;
  logic             w_res_cout;
  logic             w_res_valid;
  logic             w_ld_out;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_all_ones;
  logic [CNT_W-1:0] r_done_cnt;

  assign w_a      = (bus.sel & bus.a1) | (~bus.sel & bus.a0);
  assign w_b      = (bus.sel & bus.b1) | (~bus.sel & bus.b0);
  assign w_ld_out = ~r_out_valid | bus.out_ready;

  generate
    if (LAT == 1) begin : g_lat1
      logic [WIDTH:0] w_full;

      assign w_full       = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, bus.cin};
      assign w_res_raw    = w_full[WIDTH-1:0];
      assign w_res_cout   = w_full[WIDTH];
      assign w_res_valid  = bus.in_valid;
      assign bus.in_ready = w_ld_out;
    end else begin : g_lat2
      logic              r_v1;
      logic              r_c1;
      logic [c_half-1:0] r_lo;
      logic [c_half-1:0] r_a_hi;
      logic [c_half-1:0] r_b_hi;
      logic [c_half:0]   w_lo_add;
      logic [c_half:0]   w_hi_add;
      logic              w_ld1;

      // The low-half carry is registered so the upper half finishes the ripple next cycle
      assign w_lo_add = {1'b0, w_a[c_half-1:0]} + {1'b0, w_b[c_half-1:0]}
                      + {{c_half{1'b0}}, bus.cin};
      assign w_hi_add = {1'b0, r_a_hi} + {1'b0, r_b_hi} + {{c_half{1'b0}}, r_c1};
      assign w_ld1    = ~r_v1 | w_ld_out;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v1   <= 1'b0;
          r_c1   <= 1'b0;
          r_lo   <= '0;
          r_a_hi <= '0;
          r_b_hi <= '0;
        end else if (w_ld1) begin
          r_v1 <= bus.in_valid;
          if (bus.in_valid) begin
            r_lo   <= w_lo_add[c_half-1:0];
            r_c1   <= w_lo_add[c_half];
            r_a_hi <= w_a[WIDTH-1:c_half];
            r_b_hi <= w_b[WIDTH-1:c_half];
          end
        end
      end

      assign w_res_raw    = {w_hi_add[c_half-1:0], r_lo};
      assign w_res_cout   = w_hi_add[c_half];
      assign w_res_valid  = r_v1;
      assign bus.in_ready = w_ld1;
    end
  endgenerate

  always_comb begin
    w_sum_fin = w_res_raw;
`ifdef SAT_EN
    if (w_res_cout) begin
      w_sum_fin = '1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_all_ones  <= 1'b0;
    end else if (w_ld_out) begin
      r_out_valid <= w_res_valid;
      if (w_res_valid) begin
        r_sum      <= w_sum_fin;
        r_cout     <= w_res_cout;
        r_all_ones <= &w_sum_fin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_cnt <= '0;
    end else if (r_out_valid && bus.out_ready) begin
      r_done_cnt <= r_done_cnt + 1'b1;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.all_ones  = r_all_ones;
  assign bus.done_cnt  = r_done_cnt;
endmodule

`default_nettype wire

// File: doc/muxsel_adder_pipe.md
Name: muxsel_adder_pipe

Overview:
- Parametrised, pipelined successor to the team's mux-selected-operand adder netlist.
- Per bit, a select line picks each operand bit from one of two sources. The block adds the two operands plus carry-in and reports sum, carry-out and an all-ones flag.
- Adds a valid/ready handshake, 1- or 2-stage pipelining (split carry), a completed-result counter and optional saturation.
- Sits between operand-steering logic and a result consumer that can apply backpressure.

Parameters:
- WIDTH, 4, operand/sum width in bits; must be even and >= 2.
- LAT, 2, pipeline latency in cycles; legal values 1 or 2.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept an operand set this cycle
- sel  input  WIDTH  per-bit source select: 1 picks the *1 inputs, 0 picks the *0 inputs
- a0, a1  input  WIDTH  operand A sources
- b0, b1  input  WIDTH  operand B sources
- cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of the full-width add
- all_ones  output  1  high when sum is all ones
- done_cnt  output  CNT_W  count of results handed off (out_valid & out_ready)

Behaviour:
- Operand formation per bit i:
  - A[i] = sel[i] ? a1[i] : a0[i]
  - B[i] = sel[i] ? b1[i] : b0[i]
  - {cout, sum} = A + B + cin, computed unsigned at WIDTH+1 bits.
- Handshake:
  - A transfer occurs on a cycle with valid & ready.
  - Inputs are sampled only on an input transfer.
  - out_valid and all result outputs stay stable while out_valid=1 and out_ready=0.
- LAT=1:
  - One output register stage; the full add is computed before it.
  - Stage loads when empty, or when out_ready=1 on the same cycle.
  - in_ready = ~out_valid | out_ready. This is a combinational path from out_ready.
- LAT=2:
  - Stage 1 registers the low WIDTH/2 sum bits, the low-half carry, and the muxed upper halves of A and B.
  - Stage 2 adds the upper halves plus the registered carry and registers sum, cout and all_ones.
  - Each stage holds a valid bit. A stage loads when it is empty, or when its downstream stage is accepting on the same cycle.
  - in_ready = ~v1 | (~v2 | out_ready).
  - Full throughput is one result per cycle; two results can be in flight.
- Latency: a result appears exactly LAT cycles after its input transfer when there is no backpressure. Order is preserved, with no drops and no duplicates.
- Counter:
  - done_cnt increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0.
- all_ones = &sum, computed on the final (post-saturation) sum.
- Reset (async assert, registers update on the clock after deassert):
  - All stage valid bits, sum, cout, all_ones and done_cnt reset to 0.
  - out_valid=0 and in_ready=1 after reset.
- Boundary cases:
  - Reset mid-operation discards all in-flight results without counting them.
  - Simultaneous input and output transfer with the pipe full: the pipe advances by one, and occupancy is unchanged.
  - in_valid=1 while in_ready=0: no sampling, and the inputs have no effect.
  - Carry ripple across the half boundary (LAT=2) must equal the LAT=1 result bit-for-bit.

Optional Feature:
- Macro SAT_EN.
- Defined: when the raw add overflows (cout=1), sum is forced to all ones, so all_ones=1. cout still reports 1, so the consumer can tell saturated from exact.
- Undefined: sum is the raw low WIDTH bits (wrap-around); there is no extra logic.

Test Plan:
1. WIDTH=4, LAT=2, sel=0000, a0=0101, b0=0011, cin=0, out_ready=1 -> two cycles later out_valid=1, sum=1000, cout=0, all_ones=0, done_cnt=1.
2. sel=1010, a0=0000, a1=1010, b0=0101, b1=0000, cin=0 -> A=1010, B=0101, sum=1111, all_ones=1, cout=0. Then cin=1 -> sum=0000, cout=1, all_ones=0 (SAT_EN off), or sum=1111, cout=1, all_ones=1 (SAT_EN on).
3. LAT=2, stream 3 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepted, out_valid held with the first result stable. Raise out_ready -> results emerge in order, one per cycle, done_cnt=3.
4. Low-half carry into the upper half: A=0011, B=0001, cin=1 -> sum=0101, cout=0, identical under LAT=1 and LAT=2.
5. Assert rst with 2 results in flight -> out_valid=0, done_cnt=0, in_ready=1 immediately. Nothing is emitted after deassert until new inputs arrive.
6. CNT_W=4, 17 output transfers -> done_cnt reads 15 after 15 transfers, 0 after 16, and 1 after 17.
